core_seq: RTL and testbench
===========================

// Module: core_seq
// PURPOSE
//  Instruction sequencer that sits directly upstream of core and drives its 20-bit inst bus.
//  One start pulse runs one full job, in this order:
//   - kernel load from kmem into mac_array;
//   - drain;
//   - query execution from qmem;
//   - per-vector ofifo read, SFP accumulate, SFP divide, and psum-memory write.
//  Replaces hand-written testbench instruction streams for a single core.
// PARAMETERS
//  col      8   mac_array columns = kernels loaded per job
//  pr       8   mac_array rows (informational; sets KDRAIN default)
//  ADDR_W   4   width of qkmem_add / pmem_add fields
//  KDRAIN   8   idle cycles between kernel load and execute
//  TIMEOUT  64  max cycles to wait for ofifo_valid per output vector
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low (0 = reset)
//  start        in   1       begin job; sampled only in IDLE
//  nq           in   ADDR_W  number of query vectors, legal 1..8
//  ofifo_valid  in   1       core ofifo o_valid, exported from core
//  inst         out  20      core instruction bus (see field map)
//  busy         out  1       1 in every state except IDLE
//  done         out  1       one-cycle pulse on job completion
//  err          out  1       one-cycle pulse on illegal start or timeout
// BEHAVIOUR
//  Inst field map:
//   - [19] sfp_pmem_wr, [18] acc, [17] div, [16] ofifo_rd
//   - [15:12] qkmem_add, [11:8] pmem_add
//   - [7] execute, [6] kernel-load / kmem select
//   - [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
//  Write-enable bits [4], [2] and pmem_rd [1] are held 0.
//  All outputs are registered.
//  On reset=0: inst=0, busy=0, done=0, err=0, state=IDLE, counters=0, all immediately (async).
//  States: IDLE, KLOAD, KWAIT, EXEC, OWAIT, OREAD, ACC, DIV, PWR, DONE.
//  IDLE:
//   - start=1 and nq in 1..8: latch nq, clear vector index v, go to KLOAD.
//   - start=1 and nq=0 or nq>8: err pulses next cycle; stay IDLE.
//  KLOAD: col+1 cycles, counter c=0..col.
//   - kmem_rd=1 with qkmem_add=c while c<col.
//   - inst[6]=1 while c>=1 (SRAM has 1-cycle read latency).
//  KWAIT: KDRAIN cycles with inst=0.
//  EXEC: nq+1 cycles, c=0..nq.
//   - qmem_rd=1 with qkmem_add=c while c<nq.
//   - inst[7]=1 while c>=1; inst[6]=0.
//  OWAIT: inst=0; wait counter w increments.
//   - ofifo_valid=1: go to OREAD.
//   - w reaches TIMEOUT with no valid: err pulse, go to IDLE with inst=0; no done.
//  OREAD: ofifo_rd=1, one cycle.
//  ACC: acc=1, one cycle.
//  DIV: div=1, one cycle.
//  PWR: one cycle with pmem_wr=1, sfp_pmem_wr=1, pmem_add=v.
//   - v==nq-1: go to DONE.
//   - otherwise: v=v+1, go to OWAIT.
//  DONE: done=1 for one cycle, inst=0, then IDLE.
//  General rules:
//   - Only one phase field of inst is active in any cycle.
//   - Address fields are 0 outside their active states.
//   - start outside IDLE is ignored and not queued.
//   - done and err are never asserted in the same cycle.
//   - Counters are ADDR_W+1 bits and never wrap within a legal job (max value col=8).
//   - Timing with ofifo_valid=1 throughout: OWAIT costs 1 cycle, so each vector takes 5 cycles.
//   - Job length from the start-sampling edge to the done cycle is col+1+KDRAIN+nq+1+5*nq+1.
// STRUCTURE
//  Shared package core_seq_pkg:
//   - state enum;
//   - localparams for inst bit positions and field ranges (INST_ACC=18, INST_QK_ADD_HI=15, ...).
//  Single module with no sub-modules: one state register, cycle counter c, vector index v, wait counter w.
//  inst is built by a combinational encoder from next-state and counters, then registered.
// TESTING
//  1. reset=0 at time 0, any inputs -> inst=20'h0, busy=0, done=0, err=0; reset=0 mid-job also clears inst same cycle.
//  2. start, nq=2, ofifo_valid=1 -> kmem_rd addr 0..7; inst[6] on 8 cycles; 8 zero cycles; qmem_rd addr 0,1;
//     two OREAD/ACC/DIV/PWR groups with pmem_add 0 then 1; done once, 31 cycles after start edge.
//  3. start nq=1, ofifo_valid=0 for 70 cycles -> err pulse after 64 OWAIT cycles; IDLE; inst=0; no done.
//  4. start with nq=0 -> err one cycle, busy stays 0; start pulsed during EXEC -> ignored, single done.
//  5. reset low for 2 cycles during EXEC, then start nq=3 -> full fresh sequence, pmem_add 0,1,2, one done.
//  6. start nq=8 with ofifo_valid toggling 1/0 each cycle -> pmem_add 0..7 in order; no err; done once.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and instruction-bus field map for the core instruction sequencer.
package core_seq_pkg;

   localparam int unsigned INST_W           = 20;
   localparam int unsigned INST_SFP_PMEM_WR = 19;
   localparam int unsigned INST_ACC         = 18;
   localparam int unsigned INST_DIV         = 17;
   localparam int unsigned INST_OFIFO_RD    = 16;
   localparam int unsigned INST_QK_ADD_HI   = 15;
   localparam int unsigned INST_QK_ADD_LO   = 12;
   localparam int unsigned INST_PMEM_ADD_HI = 11;
   localparam int unsigned INST_PMEM_ADD_LO = 8;
   localparam int unsigned INST_EXEC        = 7;
   localparam int unsigned INST_KLOAD       = 6;
   localparam int unsigned INST_QMEM_RD     = 5;
   localparam int unsigned INST_QMEM_WR     = 4;
   localparam int unsigned INST_KMEM_RD     = 3;
   localparam int unsigned INST_KMEM_WR     = 2;
   localparam int unsigned INST_PMEM_RD     = 1;
   localparam int unsigned INST_PMEM_WR     = 0;

   // Largest legal query count per job
   localparam int unsigned NQ_MAX = 8;

   typedef enum logic [3:0] {
      S_IDLE,
      S_KLOAD,
      S_KWAIT,
      S_EXEC,
      S_OWAIT,
      S_OREAD,
      S_ACC,
      S_DIV,
      S_PWR,
      S_DONE
   } state_t;

endpackage

// File: rtl/core_seq.sv
// Job sequencer for one core: kernel load, drain, query execute, then per-vector
// ofifo read / accumulate / divide / psum write. All outputs are registered.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int unsigned col     = 8,
   parameter int unsigned pr      = 8,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned KDRAIN  = pr,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] nq,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned QK_W   = INST_QK_ADD_HI - INST_QK_ADD_LO + 1;
   localparam int unsigned PA_W   = INST_PMEM_ADD_HI - INST_PMEM_ADD_LO + 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_c;
   logic [CNT_W-1:0]   w_c_nxt;
   logic [CNT_W-1:0]   r_v;
   logic [CNT_W-1:0]   w_v_nxt;
   logic [WAIT_W-1:0]  r_w;
   logic [WAIT_W-1:0]  w_w_nxt;
   logic [ADDR_W-1:0]  r_nq;
   logic [ADDR_W-1:0]  w_nq_nxt;
   logic               w_nq_legal;
   logic               w_err_nxt;
   logic [INST_W-1:0]  w_inst_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   assign w_nq_legal = (nq != '0) && (CNT_W'(nq) <= CNT_W'(NQ_MAX));

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_c     <= '0;
         r_v     <= '0;
         r_w     <= '0;
         r_nq    <= '0;
         inst    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_c     <= w_c_nxt;
         r_v     <= w_v_nxt;
         r_w     <= w_w_nxt;
         r_nq    <= w_nq_nxt;
         inst    <= w_inst_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
         err     <= w_err_nxt;
      end
   end

   // Next state and counter updates
   always_comb begin
      w_state_nxt = r_state;
      w_c_nxt     = r_c;
      w_v_nxt     = r_v;
      w_w_nxt     = r_w;
      w_nq_nxt    = r_nq;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_nq_legal) begin
                  w_nq_nxt    = nq;
                  w_c_nxt     = '0;
                  w_v_nxt     = '0;
                  w_w_nxt     = '0;
                  w_state_nxt = S_KLOAD;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_KLOAD: begin
            if (r_c == CNT_W'(col)) begin
               w_c_nxt     = '0;
               w_state_nxt = S_KWAIT;
            end else begin
               w_c_nxt = r_c + CNT_W'(1);
            end
         end
         S_KWAIT: begin
            if (r_c == CNT_W'(KDRAIN - 1)) begin
               w_c_nxt     = '0;
               w_state_nxt = S_EXEC;
            end else begin
               w_c_nxt = r_c + CNT_W'(1);
            end
         end
         S_EXEC: begin
            if (r_c == CNT_W'(r_nq)) begin
               w_c_nxt     = '0;
               w_w_nxt     = '0;
               w_state_nxt = S_OWAIT;
            end else begin
               w_c_nxt = r_c + CNT_W'(1);
            end
         end
         S_OWAIT: begin
            if (ofifo_valid) begin
               w_state_nxt = S_OREAD;
            end else if (r_w == WAIT_W'(TIMEOUT - 1)) begin
               w_w_nxt     = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_w_nxt = r_w + WAIT_W'(1);
            end
         end
         S_OREAD: w_state_nxt = S_ACC;
         S_ACC:   w_state_nxt = S_DIV;
         S_DIV:   w_state_nxt = S_PWR;
         S_PWR: begin
            if (r_v == CNT_W'(r_nq) - CNT_W'(1)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_v_nxt     = r_v + CNT_W'(1);
               w_w_nxt     = '0;
               w_state_nxt = S_OWAIT;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Instruction encoder; keyed on next state so inst lines up with the registered state
   always_comb begin
      w_inst_nxt = '0;
      case (w_state_nxt)
         S_KLOAD: begin
            if (w_c_nxt < CNT_W'(col)) begin
               w_inst_nxt[INST_KMEM_RD]                    = 1'b1;
               w_inst_nxt[INST_QK_ADD_HI:INST_QK_ADD_LO]   = QK_W'(w_c_nxt);
            end
            if (w_c_nxt != '0) w_inst_nxt[INST_KLOAD] = 1'b1;
         end
         S_EXEC: begin
            if (w_c_nxt < CNT_W'(w_nq_nxt)) begin
               w_inst_nxt[INST_QMEM_RD]                    = 1'b1;
               w_inst_nxt[INST_QK_ADD_HI:INST_QK_ADD_LO]   = QK_W'(w_c_nxt);
            end
            if (w_c_nxt != '0) w_inst_nxt[INST_EXEC] = 1'b1;
         end
         S_OREAD: w_inst_nxt[INST_OFIFO_RD] = 1'b1;
         S_ACC:   w_inst_nxt[INST_ACC]      = 1'b1;
         S_DIV:   w_inst_nxt[INST_DIV]      = 1'b1;
         S_PWR: begin
            w_inst_nxt[INST_SFP_PMEM_WR]                   = 1'b1;
            w_inst_nxt[INST_PMEM_WR]                       = 1'b1;
            w_inst_nxt[INST_PMEM_ADD_HI:INST_PMEM_ADD_LO]  = PA_W'(w_v_nxt);
         end
         default: w_inst_nxt = '0;
      endcase
      // Memory write enables and pmem read are never issued by this sequencer
      w_inst_nxt[INST_QMEM_WR] = 1'b0;
      w_inst_nxt[INST_KMEM_WR] = 1'b0;
      w_inst_nxt[INST_PMEM_RD] = 1'b0;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a job-script reference model checked every cycle,
// directed scenarios with hand-computed expectations, then a randomized soak.
module tb_core_seq;

   localparam int COL     = 8;
   localparam int ADDR_W  = 4;
   localparam int KDRAIN  = 8;
   localparam int TIMEOUT = 64;
   localparam int K_OUT   = 0;
   localparam int K_WAIT  = 1;
   localparam int K_DONE  = 2;

   logic              clk         = 1'b0;
   logic              reset       = 1'b0;
   logic              start       = 1'b0;
   logic [ADDR_W-1:0] nq          = '0;
   logic              ofifo_valid = 1'b0;
   logic [19:0]       inst;
   logic              busy;
   logic              done;
   logic              err;

   core_seq #(
      .col(COL), .pr(8), .ADDR_W(ADDR_W), .KDRAIN(KDRAIN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .nq(nq), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endfunction

   // ---------------- reference model: a job is a script of expected cycles ----------------
   typedef struct {
      int          kind;
      logic [19:0] word;
   } item_t;

   item_t       script[$];
   bit          m_busy   = 1'b0;
   int          m_wait   = 0;
   logic [19:0] exp_inst = '0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err  = 1'b0;

   function automatic void push_item(input int kind, input logic [19:0] w);
      item_t it;
      it.kind = kind;
      it.word = w;
      script.push_back(it);
   endfunction

   function automatic void build_job(input int n);
      logic [19:0] w;
      script.delete();
      for (int c = 0; c <= COL; c++) begin
         w = '0;
         if (c < COL) begin w[3] = 1'b1; w[15:12] = 4'(c); end
         if (c >= 1) w[6] = 1'b1;
         push_item(K_OUT, w);
      end
      for (int i = 0; i < KDRAIN; i++) push_item(K_OUT, '0);
      for (int c = 0; c <= n; c++) begin
         w = '0;
         if (c < n) begin w[5] = 1'b1; w[15:12] = 4'(c); end
         if (c >= 1) w[7] = 1'b1;
         push_item(K_OUT, w);
      end
      for (int v = 0; v < n; v++) begin
         push_item(K_WAIT, '0);
         push_item(K_OUT, 20'h10000);
         push_item(K_OUT, 20'h40000);
         push_item(K_OUT, 20'h20000);
         w = 20'h80001;
         w[11:8] = 4'(v);
         push_item(K_OUT, w);
      end
      push_item(K_DONE, '0);
   endfunction

   function automatic void model_reset();
      script.delete();
      m_busy   = 1'b0;
      m_wait   = 0;
      exp_inst = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
   endfunction

   function automatic void model_step();
      exp_inst = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (!m_busy) begin
         if (start) begin
            if (nq >= 1 && nq <= 8) begin
               build_job(int'(nq));
               m_busy = 1'b1;
               m_wait = 0;
            end else begin
               exp_err = 1'b1;
            end
         end
         if (!m_busy) return;
      end else if (script.size() == 0) begin
         m_busy = 1'b0;
         return;
      end
      exp_busy = 1'b1;
      if (script[0].kind == K_WAIT) begin
         if (m_wait == 0) begin
            m_wait = 1;
            return;
         end
         if (!ofifo_valid) begin
            if (m_wait == TIMEOUT) begin
               script.delete();
               m_busy   = 1'b0;
               m_wait   = 0;
               exp_busy = 1'b0;
               exp_err  = 1'b1;
            end else begin
               m_wait++;
            end
            return;
         end
         void'(script.pop_front());
         m_wait = 0;
      end
      if (script[0].kind == K_DONE) exp_done = 1'b1;
      else exp_inst = script[0].word;
      void'(script.pop_front());
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   // Every-cycle comparison of DUT against the model
   function automatic void compare();
      check("inst", 32'(inst), 32'(exp_inst));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("err",  32'(err),  32'(exp_err));
   endfunction

   always @(negedge clk) compare();

   // ---------------- observation of DUT activity for directed checks ----------------
   int mon_done = 0;
   int mon_err  = 0;
   int pmem_q[$];

   function automatic void monitor();
      if (reset) begin
         if (done) mon_done++;
         if (err) mon_err++;
         if (inst[19]) pmem_q.push_back(int'(inst[11:8]));
      end
   endfunction

   function automatic void clear_mon();
      mon_done = 0;
      mon_err  = 0;
      pmem_q.delete();
   endfunction

   always @(negedge clk) monitor();

   // ---------------- ofifo_valid driver ----------------
   int vmode = 1;

   function automatic void drive_valid();
      case (vmode)
         0:       ofifo_valid = 1'b0;
         1:       ofifo_valid = 1'b1;
         2:       ofifo_valid = ~ofifo_valid;
         default: ofifo_valid = ($urandom_range(0, 9) < 7);
      endcase
   endfunction

   always @(negedge clk) begin
      #1;
      drive_valid();
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check("job_finishes", 32'(busy), 32'd0);
   endtask

   task automatic run_job(input int n, input int mode);
      vmode = mode;
      tick();
      start = 1'b1;
      nq    = 4'(n);
      tick();
      start = 1'b0;
      wait_idle(2000);
   endtask

   task automatic wait_exec();
      int n = 0;
      while (!inst[7] && n < 100) begin
         tick();
         n++;
      end
      check("reach_exec", 32'(inst[7]), 32'd1);
   endtask

   logic [19:0] tr_inst [40];
   logic        tr_done [40];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int done_idx, err_idx, kcnt, lcnt;
      logic [19:0] inst_at;
      logic        busy_at;

      // Reset state
      tick();
      tick();
      check("rst_inst", 32'(inst), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err",  32'(err),  32'd0);
      reset = 1'b1;
      tick();

      // nq=2 full job with ofifo_valid held high, cycle-accurate trace
      vmode = 1;
      clear_mon();
      tick();
      start = 1'b1;
      nq    = 4'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tr_inst[i] = inst;
         tr_done[i] = done;
         if (i < 39) tick();
      end
      done_idx = -1;
      kcnt = 0;
      lcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (tr_done[i] && done_idx < 0) done_idx = i;
         if (tr_inst[i][3]) kcnt++;
         if (tr_inst[i][6]) lcnt++;
      end
      check("t2_kload_c0",  32'(tr_inst[0]),  32'h00008);
      check("t2_kload_c1",  32'(tr_inst[1]),  32'h01048);
      check("t2_kload_c7",  32'(tr_inst[7]),  32'h07048);
      check("t2_kload_c8",  32'(tr_inst[8]),  32'h00040);
      check("t2_kwait_0",   32'(tr_inst[9]),  32'h00000);
      check("t2_kwait_7",   32'(tr_inst[16]), 32'h00000);
      check("t2_exec_c0",   32'(tr_inst[17]), 32'h00020);
      check("t2_exec_c1",   32'(tr_inst[18]), 32'h010A0);
      check("t2_exec_c2",   32'(tr_inst[19]), 32'h00080);
      check("t2_owait",     32'(tr_inst[20]), 32'h00000);
      check("t2_oread",     32'(tr_inst[21]), 32'h10000);
      check("t2_acc",       32'(tr_inst[22]), 32'h40000);
      check("t2_div",       32'(tr_inst[23]), 32'h20000);
      check("t2_pwr0",      32'(tr_inst[24]), 32'h80001);
      check("t2_pwr1",      32'(tr_inst[29]), 32'h80101);
      check("t2_done_idx",  32'(done_idx),    32'd30);
      check("t2_kmem_rd_n", 32'(kcnt),        32'd8);
      check("t2_kload_n",   32'(lcnt),        32'd8);
      check("t2_done_cnt",  32'(mon_done),    32'd1);
      check("t2_err_cnt",   32'(mon_err),     32'd0);

      // nq=1 with no ofifo_valid: timeout error, no done
      vmode = 0;
      clear_mon();
      tick();
      start = 1'b1;
      nq    = 4'd1;
      tick();
      start = 1'b0;
      err_idx = -1;
      inst_at = '1;
      busy_at = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (err && err_idx < 0) begin
            err_idx = i;
            inst_at = inst;
            busy_at = busy;
         end
         tick();
      end
      check("t3_err_idx",   32'(err_idx),  32'd83);
      check("t3_err_inst",  32'(inst_at),  32'd0);
      check("t3_err_busy",  32'(busy_at),  32'd0);
      check("t3_done_cnt",  32'(mon_done), 32'd0);
      check("t3_err_cnt",   32'(mon_err),  32'd1);

      // Illegal nq, then start pulsed during EXEC is ignored
      vmode = 1;
      tick();
      start = 1'b1;
      nq    = 4'd0;
      tick();
      start = 1'b0;
      check("t4_nq0_err",  32'(err),  32'd1);
      check("t4_nq0_busy", 32'(busy), 32'd0);
      tick();
      check("t4_err_pulse", 32'(err), 32'd0);
      start = 1'b1;
      nq    = 4'd9;
      tick();
      start = 1'b0;
      check("t4_nq9_err", 32'(err), 32'd1);
      clear_mon();
      tick();
      start = 1'b1;
      nq    = 4'd2;
      tick();
      start = 1'b0;
      wait_exec();
      start = 1'b1;
      nq    = 4'd5;
      tick();
      start = 1'b0;
      wait_idle(2000);
      check("t4_done_cnt", 32'(mon_done),       32'd1);
      check("t4_pwr_cnt",  32'(pmem_q.size()),  32'd2);

      // Reset during EXEC, then a fresh nq=3 job
      tick();
      start = 1'b1;
      nq    = 4'd3;
      tick();
      start = 1'b0;
      wait_exec();
      reset = 1'b0;
      #1;
      check("t5_rst_inst", 32'(inst), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      clear_mon();
      run_job(3, 1);
      check("t5_pwr_cnt",  32'(pmem_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) check("t5_pmem_add", 32'(pmem_q[i]), 32'(i));
      check("t5_done_cnt", 32'(mon_done), 32'd1);

      // nq=8 with toggling ofifo_valid
      clear_mon();
      run_job(8, 2);
      check("t6_pwr_cnt", 32'(pmem_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) check("t6_pmem_add", 32'(pmem_q[i]), 32'(i));
      check("t6_err_cnt",  32'(mon_err),  32'd0);
      check("t6_done_cnt", 32'(mon_done), 32'd1);

      // Randomized soak: random starts, nq values, valid pattern and rare resets
      vmode = 3;
      for (int i = 0; i < 1500; i++) begin
         tick();
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         start = ($urandom_range(0, 19) == 0);
         nq    = 4'($urandom_range(0, 15));
      end
      start = 1'b0;
      wait_idle(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
